// File: rtl/threshold_monitor_4bits.sv
// Threshold monitor: classifies each accepted 4-bit sample against a low and a
// high threshold and tracks a persistence-filtered LOW/MID/HIGH band with crossing events.
module threshold_monitor_4bits #(
  parameter int PERSIST = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic [3:0] th_hi,
  input  logic [3:0] th_lo,
  output logic [1:0] band,
  output logic       rise_evt,
  output logic       fall_evt,
  output logic [2:0] cmp_hi,
  output logic [2:0] cmp_lo,
  output logic       cfg_err
);

  localparam int CW = $clog2(PERSIST + 1);

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LOW  = 2'b01,
    MID  = 2'b10,
    HIGH = 2'b11
  } band_t;

  band_t         state, state_nx;
  band_t         cand, cand_nx;
  band_t         cls;
  logic [CW-1:0] cnt, cnt_nx, run_nx;
  logic [2:0]    cmp_hi_nx, cmp_lo_nx;
  logic          rise_nx, fall_nx;
  logic          cfg_bad, accept;

  // One-hot {gt,eq,lt} of a against b, same encoding as the upstream comparators.
  function automatic logic [2:0] cmp3(input logic [3:0] a, input logic [3:0] b);
    return {a > b, a == b, a < b};
  endfunction

  assign cfg_bad = th_lo > th_hi;
  assign accept  = in_valid && !cfg_bad;
  assign cls     = (in_data > th_hi) ? HIGH : ((in_data < th_lo) ? LOW : MID);
  assign band    = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= NONE;
      cand     <= NONE;
      cnt      <= '0;
      cmp_hi   <= 3'b000;
      cmp_lo   <= 3'b000;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cand     <= cand_nx;
      cnt      <= cnt_nx;
      cmp_hi   <= cmp_hi_nx;
      cmp_lo   <= cmp_lo_nx;
      rise_evt <= rise_nx;
      fall_evt <= fall_nx;
      cfg_err  <= cfg_bad;
    end
  end

  // A new class restarts its run at 1; a repeat of the candidate extends it.
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    cmp_hi_nx = cmp_hi;
    cmp_lo_nx = cmp_lo;
    rise_nx   = 1'b0;
    fall_nx   = 1'b0;
    run_nx    = (cls == cand) ? (cnt + CW'(1)) : CW'(1);

    if (in_valid && cfg_bad) begin
      cnt_nx = '0;
    end else if (accept) begin
      cmp_hi_nx = cmp3(in_data, th_hi);
      cmp_lo_nx = cmp3(in_data, th_lo);
      case (state)
        NONE: begin
          state_nx = cls;
        end
        default: begin
          if (cls == state) begin
            cnt_nx = '0;
          end else begin
            cand_nx = cls;
            if (run_nx == CW'(PERSIST)) begin
              state_nx = cls;
              cnt_nx   = '0;
              rise_nx  = (cls == HIGH);
              fall_nx  = (cls == LOW);
            end else begin
              cnt_nx = run_nx;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_monitor_4bits.sv
// Self-checking bench for threshold_monitor_4bits: directed scenarios plus
// randomized traffic, all compared against a run-length band model.
module tb_threshold_monitor_4bits;

  localparam int PERSIST = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic [3:0] th_hi;
  logic [3:0] th_lo;
  logic [1:0] band;
  logic       rise_evt;
  logic       fall_evt;
  logic [2:0] cmp_hi;
  logic [2:0] cmp_lo;
  logic       cfg_err;

  int passCount = 0;
  int checkCount = 0;

  // Reference model state: current band and the run of identical off-band classes
  int m_band;
  int run_q[$];
  logic [2:0] m_cmp_hi, m_cmp_lo;
  logic m_rise, m_fall, m_cfg;

  threshold_monitor_4bits #(.PERSIST(PERSIST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .th_hi(th_hi), .th_lo(th_lo), .band(band), .rise_evt(rise_evt),
    .fall_evt(fall_evt), .cmp_hi(cmp_hi), .cmp_lo(cmp_lo), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] onehot(input int a, input int b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic modelStep();
    int cls;
    if (!rst_n) begin
      m_band = 0; run_q.delete();
      m_cmp_hi = 3'b000; m_cmp_lo = 3'b000;
      m_rise = 1'b0; m_fall = 1'b0; m_cfg = 1'b0;
      return;
    end
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_cfg = (int'(th_lo) > int'(th_hi));
    if (!in_valid) return;
    if (m_cfg) begin
      run_q.delete();
      return;
    end
    if (int'(in_data) > int'(th_hi)) cls = 3;
    else if (int'(in_data) < int'(th_lo)) cls = 1;
    else cls = 2;
    m_cmp_hi = onehot(int'(in_data), int'(th_hi));
    m_cmp_lo = onehot(int'(in_data), int'(th_lo));
    if (m_band == 0) begin
      m_band = cls;
    end else if (cls == m_band) begin
      run_q.delete();
    end else begin
      if (run_q.size() > 0 && run_q[0] != cls) run_q.delete();
      run_q.push_back(cls);
      if (run_q.size() >= PERSIST) begin
        m_band = cls;
        m_rise = (cls == 3);
        m_fall = (cls == 1);
        run_q.delete();
      end
    end
  endtask

  task automatic cmpOne(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic checkOutput();
    cmpOne("band", int'(band), m_band);
    cmpOne("rise_evt", int'(rise_evt), int'(m_rise));
    cmpOne("fall_evt", int'(fall_evt), int'(m_fall));
    cmpOne("cmp_hi", int'(cmp_hi), int'(m_cmp_hi));
    cmpOne("cmp_lo", int'(cmp_lo), int'(m_cmp_lo));
    cmpOne("cfg_err", int'(cfg_err), int'(m_cfg));
    cmpOne("rise_fall_excl", int'(rise_evt & fall_evt), 0);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input int d,
                               input int lo, input int hi);
    rst_n = r;
    in_valid = v;
    in_data = 4'(d);
    th_lo = 4'(lo);
    th_hi = 4'(hi);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic sample(input int d);
    applyStimulus(1'b1, 1'b1, d, 4, 10);
  endtask

  task automatic resetThenMid();
    applyStimulus(1'b0, 1'b0, 0, 4, 10);
    sample(7);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; th_lo = 4'd4; th_hi = 4'd10;

    // Reset then init
    applyStimulus(1'b0, 1'b0, 0, 4, 10);
    applyStimulus(1'b0, 1'b0, 0, 4, 10);
    cmpOne("lit_reset_band", int'(band), 0);
    cmpOne("lit_reset_cmp_hi", int'(cmp_hi), 0);
    sample(12);
    cmpOne("lit_init_band", int'(band), 3);
    cmpOne("lit_init_rise", int'(rise_evt), 0);
    cmpOne("lit_init_cmp_hi", int'(cmp_hi), 4);
    cmpOne("lit_init_cmp_lo", int'(cmp_lo), 4);

    // Persistence
    resetThenMid();
    sample(12); sample(12);
    cmpOne("lit_persist_hold", int'(band), 2);
    sample(12);
    cmpOne("lit_persist_band", int'(band), 3);
    cmpOne("lit_persist_rise", int'(rise_evt), 1);
    applyStimulus(1'b1, 1'b0, 0, 4, 10);
    cmpOne("lit_persist_rise_end", int'(rise_evt), 0);

    // Run break
    resetThenMid();
    sample(12); sample(12); sample(2); sample(12); sample(12);
    cmpOne("lit_break_hold", int'(band), 2);
    sample(12);
    cmpOne("lit_break_band", int'(band), 3);
    cmpOne("lit_break_rise", int'(rise_evt), 1);

    // Bubbles and equality
    resetThenMid();
    sample(3);
    repeat (3) applyStimulus(1'b1, 1'b0, 9, 4, 10);
    sample(3);
    cmpOne("lit_bubble_hold", int'(band), 2);
    sample(3);
    cmpOne("lit_bubble_band", int'(band), 1);
    cmpOne("lit_bubble_fall", int'(fall_evt), 1);
    sample(4);
    cmpOne("lit_eq_lo_cmp", int'(cmp_lo), 2);
    sample(10);
    cmpOne("lit_eq_hi_cmp", int'(cmp_hi), 2);
    cmpOne("lit_eq_band", int'(band), 1);

    // Config error
    repeat (5) applyStimulus(1'b1, 1'b1, 15, 9, 5);
    cmpOne("lit_cfg_err", int'(cfg_err), 1);
    cmpOne("lit_cfg_band", int'(band), 1);
    cmpOne("lit_cfg_cmp_hi", int'(cmp_hi), 2);
    applyStimulus(1'b1, 1'b0, 0, 4, 10);
    cmpOne("lit_cfg_clear", int'(cfg_err), 0);
    sample(12); sample(12);
    cmpOne("lit_cfg_restart", int'(band), 1);
    sample(12);
    cmpOne("lit_cfg_high", int'(band), 3);

    // Mid-run reset
    resetThenMid();
    sample(12); sample(12);
    applyStimulus(1'b0, 1'b1, 12, 4, 10);
    cmpOne("lit_midrst_band", int'(band), 0);
    cmpOne("lit_midrst_cmp_lo", int'(cmp_lo), 0);
    sample(2);
    cmpOne("lit_midrst_low", int'(band), 1);
    cmpOne("lit_midrst_nofall", int'(fall_evt), 0);

    // Randomized traffic with drifting thresholds and occasional resets
    begin
      int lo = 4;
      int hi = 10;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          int a = int'($urandom_range(0, 15));
          int b = int'($urandom_range(0, 15));
          if ($urandom_range(0, 4) != 0 && a > b) begin
            lo = b; hi = a;
          end else begin
            lo = a; hi = b;
          end
        end
        applyStimulus($urandom_range(0, 99) >= 2, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 15)), lo, hi);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/threshold_monitor_4bits.md
# threshold_monitor_4bits

Sequential threshold monitor placed directly downstream of the 4-bit magnitude comparators. Each accepted 4-bit sample is compared against a high and a low threshold using the same one-hot {gt,eq,lt} encoding as the comparators. The block tracks which band the signal is in (LOW / MID / HIGH) with a persistence filter, and emits single-cycle crossing events. It is used to debounce noisy compare results before they reach control logic.

## Interface
- PERSIST, 3: consecutive valid samples of a new band required before a band change; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_data is a sample this cycle
- in_data  in  4  unsigned sample
- th_hi  in  4  unsigned high threshold
- th_lo  in  4  unsigned low threshold
- band  out  2  00 NONE, 01 LOW, 10 MID, 11 HIGH
- rise_evt  out  1  one-cycle pulse on entry to HIGH
- fall_evt  out  1  one-cycle pulse on entry to LOW
- cmp_hi  out  3  one-hot {gt,eq,lt} of last accepted sample vs th_hi
- cmp_lo  out  3  one-hot {gt,eq,lt} of last accepted sample vs th_lo
- cfg_err  out  1  th_lo > th_hi this cycle (registered)

## Operation
- Sample classification, for unsigned 4-bit values:
  - HIGH if in_data > th_hi.
  - LOW if in_data < th_lo.
  - Otherwise MID; equality with either threshold is MID.
- A sample is accepted when in_valid=1 and th_lo <= th_hi.
- If in_valid=1 and th_lo > th_hi, the sample is discarded:
  - band is held.
  - The candidate counter is cleared.
  - cmp_hi and cmp_lo are held.
- FSM states NONE, LOW, MID, HIGH. NONE is entered only from reset.
- NONE: the first accepted sample sets band to its class immediately, with no persistence and no event.
- LOW, MID, HIGH: each accepted sample updates the internal candidate band and counter (width clog2(PERSIST+1)):
  - class == band: counter cleared.
  - class != band and class == candidate: counter increments.
  - class != band and class != candidate: candidate = class, counter = 1.
  - When the counter reaches PERSIST: band = candidate and counter is cleared in the same edge.
- PERSIST=1: band follows each accepted sample immediately.
- Direct LOW<->HIGH jumps are allowed.
- Events:
  - rise_evt pulses on any transition into HIGH from LOW or MID.
  - fall_evt pulses on any transition into LOW from MID or HIGH.
  - NONE->any never raises an event.
  - rise_evt and fall_evt are never high together.
- Cycles with in_valid=0 leave band, counter, candidate, cmp_* and events (0) unaffected; the persistence run is not broken.
- Thresholds may change at any time. The new values apply from the next accepted sample; a threshold change alone does not clear the counter.

## Timing
- All outputs are registered.
- Reset values: band=00, rise_evt=0, fall_evt=0, cmp_hi=000, cmp_lo=000, cfg_err=0. Internal counter=0, candidate=NONE.
- Latency: sample accepted at edge N. At edge N, cmp_hi, cmp_lo and band (if a transition occurs) update, and the event is high for the cycle following edge N only.
- Throughput: one sample per cycle, no backpressure.
- cfg_err reflects the th_lo/th_hi relation sampled at the previous edge.
- rst_n low at any edge overrides everything, including an in-flight persistence run or a pending event. The first accepted sample after reset re-initialises band from NONE.

## Test plan
- Reset then init: rst_n=0 for 2 cycles, then th_lo=4, th_hi=10, one sample 12 -> band=11, rise_evt stays 0, cmp_hi=100, cmp_lo=100.
- Persistence, PERSIST=3: from band=MID (sample 7), samples 12,12 -> band stays 10. Third 12 -> band=11 and rise_evt is a single one-cycle pulse.
- Run break: MID, samples 12,12,2,12,12 -> no change. Then 12 -> HIGH, and rise_evt fires only on that edge.
- Bubbles and equality: from MID, samples 3,(in_valid=0 x3),3,3 -> band=01 with fall_evt on the third 3. Then samples 4 and 10 at th_lo=4, th_hi=10 count as MID.
- Config error: th_lo=9, th_hi=5, samples 15 x5 -> cfg_err=1, band and cmp_* held. Restoring th_lo=4, th_hi=10 -> cfg_err=0 next cycle and counting restarts from 0.
- Mid-run reset: two HIGH-candidate samples, then rst_n=0 for 1 cycle -> all outputs at reset values. The next sample 2 sets band=01 with no fall_evt.
